snoop_dispatch: RTL and testbench

SNOOP_DISPATCH -- requirements
Module: snoop_dispatch

---
 rtl/snoop_dispatch.sv | 116 +++++++++++
 tb/tb_snoop_dispatch.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/snoop_dispatch.sv
// rtl/snoop_dispatch.sv - routes one snooper packet at a time to a round-robin selected packet-filter VM
module snoop_dispatch #(
  parameter  int N          = 5,
  parameter  int ADDR_WIDTH = 9,
  parameter  int DATA_WIDTH = 64,
  localparam int SEL_WIDTH  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    axi_aclk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   snooper_wr_addr,
  input  logic [DATA_WIDTH-1:0]   snooper_wr_data,
  input  logic                    snooper_wr_en,
  input  logic                    snooper_done,
  output logic                    ready_for_snooper,
  output logic [N*ADDR_WIDTH-1:0] vm_wr_addr,
  output logic [N*DATA_WIDTH-1:0] vm_wr_data,
  output logic [N-1:0]            vm_wr_en,
  output logic [N-1:0]            vm_done,
  input  logic [N-1:0]            vm_ready,
  output logic [SEL_WIDTH-1:0]    grant_sel,
  output logic [15:0]             pkt_count
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]           state_q,     state_d;
  logic [SEL_WIDTH-1:0] ptr_q,       ptr_d;
  logic [SEL_WIDTH-1:0] grant_sel_q, grant_sel_d;
  logic [15:0]          pkt_count_q, pkt_count_d;

  logic                 found;
  logic [SEL_WIDTH-1:0] pick;
  logic [SEL_WIDTH-1:0] idx_sel;
  logic [SEL_WIDTH-1:0] next_ptr;
  int                   idx;
  logic                 locked_live;

  // Round-robin scan starting at ptr_q; the first ready VM wins.
  always_comb begin
    found   = 1'b0;
    pick    = grant_sel_q;
    idx     = 0;
    idx_sel = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      idx_sel = SEL_WIDTH'(idx);
      if (!found && vm_ready[idx_sel]) begin
        found = 1'b1;
        pick  = idx_sel;
      end
    end
  end

  always_comb begin
    if (grant_sel_q == SEL_WIDTH'(N - 1)) next_ptr = '0;
    else                                  next_ptr = grant_sel_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_sel_d = grant_sel_q;
    pkt_count_d = pkt_count_q;
    case (state_q)
      SEARCH: begin
        if (found) begin
          grant_sel_d = pick;
          state_d     = LOCKED;
        end
      end
      LOCKED: begin
        // Only end-of-packet releases the lock; a ready drop just stalls the snooper.
        if (snooper_done) begin
          ptr_d       = next_ptr;
          pkt_count_d = pkt_count_q + 16'd1;
          state_d     = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      state_q     <= SEARCH;
      ptr_q       <= '0;
      grant_sel_q <= '0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_sel_q <= grant_sel_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign locked_live = (state_q == LOCKED) && !rst;

  always_comb begin
    vm_wr_en = '0;
    vm_done  = '0;
    if (locked_live) begin
      vm_wr_en[grant_sel_q] = snooper_wr_en;
      vm_done[grant_sel_q]  = snooper_done;
    end
  end

  assign ready_for_snooper = locked_live && vm_ready[grant_sel_q];
  assign vm_wr_addr        = {N{snooper_wr_addr}};
  assign vm_wr_data        = {N{snooper_wr_data}};
  assign grant_sel         = grant_sel_q;
  assign pkt_count         = pkt_count_q;

endmodule

// File: tb/tb_snoop_dispatch.sv
// tb/tb_snoop_dispatch.sv - scoreboard bench for snoop_dispatch grants, routing, reset and counter wrap
module tb_snoop_dispatch;

  localparam int N  = 5;
  localparam int AW = 9;
  localparam int DW = 64;
  localparam int SW = 3;

  logic            axi_aclk = 1'b0;
  logic            rst;
  logic [AW-1:0]   snooper_wr_addr;
  logic [DW-1:0]   snooper_wr_data;
  logic            snooper_wr_en;
  logic            snooper_done;
  logic            ready_for_snooper;
  logic [N*AW-1:0] vm_wr_addr;
  logic [N*DW-1:0] vm_wr_data;
  logic [N-1:0]    vm_wr_en;
  logic [N-1:0]    vm_done;
  logic [N-1:0]    vm_ready;
  logic [SW-1:0]   grant_sel;
  logic [15:0]     pkt_count;

  int          checks = 0;
  int          errors = 0;
  int          sb[$];
  logic [15:0] exp_count;

  snoop_dispatch #(.N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .axi_aclk          (axi_aclk),
    .rst               (rst),
    .snooper_wr_addr   (snooper_wr_addr),
    .snooper_wr_data   (snooper_wr_data),
    .snooper_wr_en     (snooper_wr_en),
    .snooper_done      (snooper_done),
    .ready_for_snooper (ready_for_snooper),
    .vm_wr_addr        (vm_wr_addr),
    .vm_wr_data        (vm_wr_data),
    .vm_wr_en          (vm_wr_en),
    .vm_done           (vm_done),
    .vm_ready          (vm_ready),
    .grant_sel         (grant_sel),
    .pkt_count         (pkt_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ready_for_snooper !== 1'b1 && n < 50) begin
      tick();
      #1;
      n++;
    end
    chk({tag, " ready"}, 64'(ready_for_snooper), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    snooper_wr_en = 1'b0;
    snooper_done  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    exp_count = 16'd0;
    #1;
  endtask

  task automatic run_pkt(input string tag, input int nwr);
    int g;
    wait_ready(tag);
    g = (sb.size() > 0) ? sb.pop_front() : -1;
    chk({tag, " grant"}, 64'(grant_sel), 64'(g));
    for (int i = 0; i < nwr; i++) begin
      snooper_wr_addr = AW'($urandom);
      snooper_wr_data = {$urandom, $urandom};
      snooper_wr_en   = 1'b1;
      #1;
      chk({tag, " wr_en"}, 64'(vm_wr_en), 64'(5'd1 << g));
      chk({tag, " addr"}, 64'(vm_wr_addr[g*AW +: AW]), 64'(snooper_wr_addr));
      chk({tag, " data"}, vm_wr_data[g*DW +: DW], snooper_wr_data);
      tick();
    end
    snooper_wr_en = 1'b0;
    snooper_done  = 1'b1;
    #1;
    chk({tag, " done"}, 64'(vm_done), 64'(5'd1 << g));
    exp_count = exp_count + 16'd1;
    tick();
    snooper_done = 1'b0;
    #1;
    chk({tag, " count"}, 64'(pkt_count), 64'(exp_count));
    chk({tag, " release"}, 64'(ready_for_snooper), 64'd0);
  endtask

  initial begin
    int exp_str, got_str;
    rst = 1'b1;
    snooper_wr_addr = '0;
    snooper_wr_data = '0;
    snooper_wr_en   = 1'b1;
    snooper_done    = 1'b1;
    vm_ready        = '1;
    tick();
    tick();
    #1;
    chk("rst ready", 64'(ready_for_snooper), 64'd0);
    chk("rst wr_en", 64'(vm_wr_en), 64'd0);
    chk("rst done", 64'(vm_done), 64'd0);
    chk("rst grant", 64'(grant_sel), 64'd0);
    chk("rst count", 64'(pkt_count), 64'd0);
    do_reset();

    // All VMs ready: pure rotation with wrap back to VM 0.
    sb.push_back(0); sb.push_back(1); sb.push_back(2);
    sb.push_back(3); sb.push_back(4); sb.push_back(0);
    for (int p = 0; p < 6; p++) run_pkt("rr", 1 + p % 3);
    chk("rr total", 64'(pkt_count), 64'd6);

    // Sparse ready set: skip unready VMs from the pointer onwards.
    do_reset();
    vm_ready = 5'b10100;
    sb.push_back(2); sb.push_back(4);
    run_pkt("sparse", 2);
    run_pkt("sparse", 1);

    // Idle: strobes in SEARCH are dropped, nothing is granted.
    do_reset();
    vm_ready = '0;
    for (int c = 0; c < 10; c++) begin
      snooper_wr_en = c[0];
      snooper_done  = (c == 5);
      #1;
      chk("idle ready", 64'(ready_for_snooper), 64'd0);
      chk("idle wr_en", 64'(vm_wr_en), 64'd0);
      chk("idle done", 64'(vm_done), 64'd0);
      tick();
    end
    snooper_wr_en = 1'b0;
    snooper_done  = 1'b0;
    #1;
    chk("idle count", 64'(pkt_count), 64'd0);
    vm_ready = 5'b00010;
    #1;
    chk("rise same", 64'(ready_for_snooper), 64'd0);
    tick();
    #1;
    chk("rise next", 64'(ready_for_snooper), 64'd1);
    sb.push_back(1);
    run_pkt("rise", 1);

    // Lock on VM 3: only its strobes pass, and a ready drop keeps the lock.
    vm_ready = 5'b01000;
    sb.push_back(3);
    wait_ready("lock3");
    chk("lock3 grant", 64'(grant_sel), 64'(sb.pop_front()));
    exp_str = 0;
    got_str = 0;
    for (int c = 0; c < 12; c++) begin
      snooper_wr_en = 1'($urandom);
      if (c == 4) vm_ready = 5'b00111;
      if (c == 8) vm_ready = 5'b01000;
      #1;
      if (snooper_wr_en) exp_str++;
      if (vm_wr_en[3]) got_str++;
      chk("lock3 others", 64'(vm_wr_en & 5'b10111), 64'd0);
      if (c == 5) begin
        chk("lock3 drop ready", 64'(ready_for_snooper), 64'd0);
        chk("lock3 drop grant", 64'(grant_sel), 64'd3);
      end
      tick();
    end
    snooper_wr_en = 1'b0;
    #1;
    chk("lock3 strobes", 64'(got_str), 64'(exp_str));
    chk("lock3 back", 64'(ready_for_snooper), 64'd1);
    sb.push_back(3);
    run_pkt("lock3", 0);

    // Reset mid-packet on VM 2 with a coincident done pulse.
    vm_ready = 5'b00100;
    sb.push_back(2);
    wait_ready("midrst");
    chk("midrst grant", 64'(grant_sel), 64'(sb.pop_front()));
    snooper_wr_en = 1'b1;
    tick();
    snooper_wr_en = 1'b0;
    rst = 1'b1;
    snooper_done = 1'b1;
    #1;
    chk("midrst done", 64'(vm_done), 64'd0);
    chk("midrst ready", 64'(ready_for_snooper), 64'd0);
    tick();
    #1;
    chk("midrst grant0", 64'(grant_sel), 64'd0);
    chk("midrst count", 64'(pkt_count), 64'd0);
    chk("midrst done2", 64'(vm_done), 64'd0);
    snooper_done = 1'b0;
    rst = 1'b0;
    exp_count = 16'd0;

    // Counter wrap: jump near the top, then dispatch real packets across 2^16.
    vm_ready = '1;
    tick();
    force dut.pkt_count_q = 16'hFFFD;
    #1;
    release dut.pkt_count_q;
    exp_count = 16'hFFFD;
    sb.push_back(0); sb.push_back(1); sb.push_back(2);
    for (int p = 0; p < 3; p++) run_pkt("wrap", 1);
    chk("wrap zero", 64'(pkt_count), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
